mul_share_arbiter: RTL

//  Shares a single signed/unsigned n x n multiplier between two requesters.

---
 rtl/mul_share_arbiter_if.sv | 31 +++
 rtl/mul_share_arbiter.sv | 130 +++++++++++++
 2 files changed

// File: rtl/mul_share_arbiter_if.sv
// Request/response bundle between two client pipeline stages and the
// shared multiplier arbiter. Bit i of each 2-bit vector belongs to requester i.
interface mul_share_arbiter_if #(
  parameter int n = 8
);
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [n-1:0]   req_a0;
  logic [n-1:0]   req_b0;
  logic           req_signed0;
  logic [n-1:0]   req_a1;
  logic [n-1:0]   req_b1;
  logic           req_signed1;
  logic [1:0]     rsp_valid;
  logic [1:0]     rsp_ready;
  logic [2*n-1:0] rsp_res;

  // Client side: issues requests, consumes responses.
  modport master (
    output req_valid, req_a0, req_b0, req_signed0,
    output req_a1, req_b1, req_signed1, rsp_ready,
    input  req_ready, rsp_valid, rsp_res
  );

  // Arbiter side: accepts requests, produces responses.
  modport slave (
    input  req_valid, req_a0, req_b0, req_signed0,
    input  req_a1, req_b1, req_signed1, rsp_ready,
    output req_ready, rsp_valid, rsp_res
  );
endinterface

// File: rtl/mul_share_arbiter.sv
// Shares one n x n signed/unsigned multiplier between two requesters.
// Round-robin grant in IDLE, one operation in flight, operands and
// product held in registers. Flow: IDLE -> MUL -> RESP -> IDLE.
module mul_share_arbiter #(
  parameter int n = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mul_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r;
  state_t         state_s;
  logic [n-1:0]   a_r;
  logic [n-1:0]   b_r;
  logic           signed_r;
  logic           owner_r;
  logic           last_r;
  logic [2*n-1:0] res_r;
  logic           grant_s;
  logic           load_s;
  logic           done_s;
  logic [1:0]     req_ready_s;

  // Extend both operands to 2n (sign or zero) and keep the low 2n product bits;
  // in two's complement this gives the exact signed product.
  function automatic logic [2*n-1:0] mul_ext(
    input logic [n-1:0] a,
    input logic [n-1:0] b,
    input logic         sgn
  );
    logic [2*n-1:0] ax;
    logic [2*n-1:0] bx;
    ax = sgn ? {{n{a[n-1]}}, a} : {{n{1'b0}}, a};
    bx = sgn ? {{n{b[n-1]}}, b} : {{n{1'b0}}, b};
    return ax * bx;
  endfunction

  // Next state, grant selection and request-accept decode.
  always_comb begin
    state_s     = state_r;
    grant_s     = 1'b0;
    load_s      = 1'b0;
    done_s      = 1'b0;
    req_ready_s = 2'b00;
    case (state_r)
      IDLE: begin
        if (bus.req_valid != 2'b00) begin
          if (bus.req_valid == 2'b11) begin
            grant_s = ~last_r;
          end else begin
            grant_s = bus.req_valid[1];
          end
          req_ready_s = grant_s ? 2'b10 : 2'b01;
          load_s      = 1'b1;
          state_s     = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL: begin
        state_s = RESP;
      end
      RESP: begin
        if (bus.rsp_ready[owner_r]) begin
          done_s  = 1'b1;
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Capture the granted requester's operands, flag and identity on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= {n{1'b0}};
      b_r      <= {n{1'b0}};
      signed_r <= 1'b0;
      owner_r  <= 1'b0;
    end else if (load_s) begin
      a_r      <= grant_s ? bus.req_a1 : bus.req_a0;
      b_r      <= grant_s ? bus.req_b1 : bus.req_b0;
      signed_r <= grant_s ? bus.req_signed1 : bus.req_signed0;
      owner_r  <= grant_s;
    end
  end

  // Product register; keeps its value after the response is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_r <= {(2*n){1'b0}};
    end else if (state_r == MUL) begin
      res_r <= mul_ext(a_r, b_r, signed_r);
    end
  end

  // Round-robin pointer: the owner of the last completed response loses the next tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (done_s) begin
      last_r <= owner_r;
    end
  end

  assign bus.req_ready = req_ready_s;
  assign bus.rsp_valid = (state_r == RESP) ? (owner_r ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_res   = res_r;

endmodule
